// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the fill FSM state type, block/word geometry and the derived
// address field widths used by the cache, its fill FSM and its interface.
package instruction_cache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned OFFSET_W   = 4;
    localparam int unsigned SETS       = 8;
    localparam int unsigned INDEX_W    = $clog2(SETS);
    localparam int unsigned TAG_W      = ADDR_W - OFFSET_W - INDEX_W;
    localparam int unsigned MEM_ADDR_W = ADDR_W - OFFSET_W;
    localparam int unsigned WORDS      = BLOCK_W / WORD_W;

    typedef enum logic [1:0] {
        StIdle,
        StMemReq,
        StMemWait
    } fill_state_e;

endpackage

// File: rtl/instruction_cache_if.sv
// Bus bundle between the CPU fetch stage, the instruction cache and the
// block instruction memory.
//   read/address        : CPU fetch request (byte address)
//   instruction/busywait: fetched word and CPU stall
//   mem_read/mem_address: block read request to memory
//   mem_readdata/mem_busywait: returned block and memory busy flag
// Modport slave is the cache side; master is the CPU + memory side.
interface instruction_cache_if;
    import instruction_cache_pkg::*;

    logic                  read;
    logic [ADDR_W-1:0]     address;
    logic [WORD_W-1:0]     instruction;
    logic                  busywait;
    logic                  mem_read;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  read, address, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

    modport master (
        output read, address, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );

endinterface

// File: rtl/icache_fill_fsm.sv
// Miss handling FSM for the instruction cache.
// Ports:
//   clock, reset     : clock and asynchronous active-low reset
//   miss_i           : lookup missed (only acted on while idle)
//   miss_block_i     : block address {tag, index} of the missing fetch
//   mem_busywait_i   : memory busy
//   idle_o           : FSM in IDLE, lookups may hit
//   mem_read_o       : block read request
//   mem_address_o    : latched block address, held between fills
//   fill_en_o        : one-cycle pulse, mem_readdata is final this cycle
module icache_fill_fsm
    import instruction_cache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss_i,
    input  logic [MEM_ADDR_W-1:0] miss_block_i,
    input  logic                  mem_busywait_i,
    output logic                  idle_o,
    output logic                  mem_read_o,
    output logic [MEM_ADDR_W-1:0] mem_address_o,
    output logic                  fill_en_o
);

    fill_state_e           state_q, state_d;
    logic [MEM_ADDR_W-1:0] block_q, block_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        block_d    = block_q;
        mem_read_o = 1'b0;
        fill_en_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (miss_i) begin
                    block_d = miss_block_i;
                    state_d = StMemReq;
                end
            end
            // One request cycle so memory can register it and raise busywait.
            StMemReq: begin
                mem_read_o = 1'b1;
                state_d    = StMemWait;
            end
            StMemWait: begin
                mem_read_o = 1'b1;
                if (!mem_busywait_i) begin
                    fill_en_o = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign idle_o        = (state_q == StIdle);
    assign mem_address_o = block_q;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache.
// Hits return the addressed word combinationally; misses stall the CPU with
// busywait while icache_fill_fsm fetches the 16-byte block.
// Ports:
//   clock, reset : clock and asynchronous active-low reset
//   bus          : CPU fetch and block memory signals (slave modport)
module instruction_cache
    import instruction_cache_pkg::*;
(
    input logic                 clock,
    input logic                 reset,
    instruction_cache_if.slave  bus
);

    typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

    logic [SETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [SETS];
    block_t           data_q [SETS];

    logic [TAG_W-1:0]         addr_tag;
    logic [INDEX_W-1:0]       addr_index;
    logic [$clog2(WORDS)-1:0] addr_word;
    logic                     idle;
    logic                     hit;
    logic                     fill_en;
    logic [INDEX_W-1:0]       fill_index;
    logic [TAG_W-1:0]         fill_tag;
    logic                     unused_addr_bits;

    assign addr_tag         = bus.address[ADDR_W-1 -: TAG_W];
    assign addr_index       = bus.address[OFFSET_W +: INDEX_W];
    assign addr_word        = bus.address[2 +: $clog2(WORDS)];
    assign unused_addr_bits = ^bus.address[1:0];

    assign hit = bus.read && idle && valid_q[addr_index] && (tag_q[addr_index] == addr_tag);

    assign bus.busywait    = bus.read && !hit;
    assign bus.instruction = data_q[addr_index][addr_word];

    // busywait doubles as the miss request; the FSM only samples it while idle.
    icache_fill_fsm u_fill_fsm (
        .clock          (clock),
        .reset          (reset),
        .miss_i         (bus.busywait),
        .miss_block_i   (bus.address[ADDR_W-1:OFFSET_W]),
        .mem_busywait_i (bus.mem_busywait),
        .idle_o         (idle),
        .mem_read_o     (bus.mem_read),
        .mem_address_o  (bus.mem_address),
        .fill_en_o      (fill_en)
    );

    assign fill_index = bus.mem_address[INDEX_W-1:0];
    assign fill_tag   = bus.mem_address[MEM_ADDR_W-1:INDEX_W];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // Tag and data arrays are qualified by valid_q and need no reset.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= bus.mem_readdata;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed fetches, a block memory
// model with programmable latency, and scoreboards for fetched words and for
// block requests, checked by monitors on the falling clock edge.
module tb_instruction_cache;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instruction_cache_if bus ();

    instruction_cache dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    int             lat = 16;
    int             cnt;
    logic           mem_busy;
    logic           mem_done;
    logic [127:0]   mem_data;

    function automatic logic [31:0] mem_word(input logic [27:0] blk, input int k);
        logic [1:0] kk;
        kk = k[1:0];
        if (blk == 28'h0 && kk == 2'd0) return 32'h3E800093;
        return 32'hA5000000 ^ {blk[19:0], 10'd0, kk};
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] blk);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) b[k*32 +: 32] = mem_word(blk, k);
        return b;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
            cnt      <= 0;
            mem_data <= '0;
        end else begin
            if (!bus.mem_read) mem_done <= 1'b0;
            if (mem_busy) begin
                if (cnt == 0) begin
                    mem_busy <= 1'b0;
                    mem_done <= 1'b1;
                    mem_data <= mem_block(bus.mem_address);
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (bus.mem_read && !mem_done) begin
                mem_busy <= 1'b1;
                cnt      <= lat - 1;
                mem_data <= {4{32'hBAD0BAD0}};
            end
        end
    end

    assign bus.mem_busywait = mem_busy;
    assign bus.mem_readdata = mem_data;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    logic [27:0] memq[$];
    logic        mr_prev = 1'b0;
    logic [27:0] ma_prev = '0;

    always @(negedge clock) begin
        if (reset && bus.read && !bus.busywait) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch", {32'd0, bus.instruction}, 64'hFFFFFFFF_FFFFFFFF);
            end else begin
                check("instruction", {32'd0, bus.instruction}, {32'd0, exp_q.pop_front()});
            end
        end
        if (bus.mem_read && !mr_prev) begin
            if (memq.size() == 0) begin
                check("unexpected_mem_read", {36'd0, bus.mem_address}, 64'hFFFFFFFF_FFFFFFFF);
            end else begin
                check("mem_address", {36'd0, bus.mem_address}, {36'd0, memq.pop_front()});
            end
        end
        if (bus.mem_read && mr_prev) begin
            check("mem_address_stable", {36'd0, bus.mem_address}, {36'd0, ma_prev});
        end
        mr_prev = bus.mem_read;
        ma_prev = bus.mem_address;
    end

    // Fetch one word; returns the number of stalled cycles.
    task automatic fetch(input logic [31:0] a, output int stalls);
        bit done;
        exp_q.push_back(mem_word(a[31:4], int'(a[3:2])));
        bus.read    = 1'b1;
        bus.address = a;
        stalls      = 0;
        done        = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (!bus.busywait) done = 1;
            else stalls++;
        end
        if (!done) check("fetch_timeout", 64'd1, 64'd0);
        @(posedge clock);
        #1;
        bus.read = 1'b0;
    endtask

    initial begin
        int s;
        bit done;
        bus.read    = 1'b0;
        bus.address = '0;

        // Reset state
        #2;
        check("rst_mem_read", {63'd0, bus.mem_read}, 64'd0);
        check("rst_mem_address", {36'd0, bus.mem_address}, 64'd0);
        check("rst_busywait_idle", {63'd0, bus.busywait}, 64'd0);
        bus.read = 1'b1;
        #1;
        check("rst_busywait_read", {63'd0, bus.busywait}, 64'd1);
        bus.read = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Cold miss
        memq.push_back(28'h0);
        fetch(32'h0, s);
        check("cold_stalls", 64'(s), 64'd19);

        // Hits in the filled line
        fetch(32'h4, s);
        check("hit4_stalls", 64'(s), 64'd0);
        fetch(32'h8, s);
        check("hit8_stalls", 64'(s), 64'd0);
        fetch(32'hC, s);
        check("hitC_stalls", 64'(s), 64'd0);

        // Conflict on index 0
        memq.push_back(28'h8);
        fetch(32'h80, s);
        check("conflict_stalls", 64'(s), 64'd19);
        memq.push_back(28'h0);
        fetch(32'h0, s);
        check("refetch_stalls", 64'(s), 64'd19);

        // Reset in the middle of a fill of block 4
        memq.push_back(28'h4);
        bus.read    = 1'b1;
        bus.address = 32'h40;
        repeat (6) @(negedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_mem_read", {63'd0, bus.mem_read}, 64'd0);
        check("midrst_mem_address", {36'd0, bus.mem_address}, 64'd0);
        check("midrst_busywait_read", {63'd0, bus.busywait}, 64'd1);
        bus.read = 1'b0;
        #1;
        check("midrst_busywait_idle", {63'd0, bus.busywait}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        memq.push_back(28'h0);
        fetch(32'h0, s);
        check("after_rst_stalls", 64'(s), 64'd19);

        // Address change during a fill
        memq.push_back(28'h8);
        fetch(32'h80, s);
        check("evict_stalls", 64'(s), 64'd19);
        memq.push_back(28'h0);
        memq.push_back(28'h1);
        bus.read    = 1'b1;
        bus.address = 32'h0;
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1;
        bus.read    = 1'b0;
        bus.address = 32'h10;
        repeat (3) @(posedge clock);
        #1;
        exp_q.push_back(mem_word(28'h1, 0));
        bus.read = 1'b1;
        done     = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (!bus.busywait) done = 1;
        end
        check("midchg_completes", {63'd0, done}, 64'd1);
        @(posedge clock);
        #1;
        bus.read = 1'b0;
        fetch(32'h0, s);
        check("midchg_block0_hit", 64'(s), 64'd0);

        // Stretched memory latency
        lat = 40;
        memq.push_back(28'h10);
        fetch(32'h100, s);
        check("stretch_stalls", 64'(s), 64'd43);
        lat = 16;

        repeat (2) @(posedge clock);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("memq_empty", 64'(memq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the CPU fetch stage and the 128-bit block instruction memory. Returns a 32-bit instruction on a hit in the same cycle. On a miss it stalls the CPU with `busywait`, fetches the 16-byte block over the memory read/busywait handshake, installs it, and then completes the fetch.

## Interface
- `SETS`, 8 — number of cache lines; power of two.
- `INDEX_W`, 3 — log2(`SETS`).
- `TAG_W`, 25 — 32 − 4 − `INDEX_W`.
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low; asserted (0) clears state immediately.
- `read`  in  1  — CPU fetch request valid.
- `address`  in  32  — CPU byte address (PC); bits [1:0] ignored.
- `instruction`  out  32  — fetched word; valid when `read`=1 and `busywait`=0.
- `busywait`  out  1  — CPU stall.
- `mem_read`  out  1  — block read request to instruction memory.
- `mem_address`  out  28  — block address, equal to byte address [31:4].
- `mem_readdata`  in  128  — returned block; byte 0 in bits [7:0].
- `mem_busywait`  in  1  — memory busy; falls when `mem_readdata` is final.

## Operation
- Address split: tag = [31:7], index = [6:4], word offset = [3:2].
- Per line: valid bit, tag (`TAG_W`), data (128). Word k = data[32k+31:32k].
- Hit = `read` ∧ state=IDLE ∧ valid[index] ∧ tag[index]==address tag. Hit is combinational.
- `instruction` = selected word of line[index], driven combinationally.
- `busywait` = `read` ∧ ¬hit, combinational. `busywait`=0 whenever `read`=0.
- FSM states are IDLE, MEM_REQ and MEM_WAIT.
  - IDLE: on `read` ∧ ¬hit, latch miss tag and index, then go to MEM_REQ.
  - MEM_REQ: assert `mem_read`; `mem_address`={latched tag, latched index}. Stays exactly 1 cycle, so memory registers the request and raises `mem_busywait`. Then go to MEM_WAIT.
  - MEM_WAIT: hold `mem_read`=1 and `mem_address` stable. At the edge where `mem_busywait`=0:
    - write `mem_readdata` into line[latched index];
    - set tag = latched tag, valid = 1;
    - go to IDLE.
- Outside MEM_REQ/MEM_WAIT, `mem_read`=0 and `mem_address` holds its last value.
- While a fill is in flight, changes to `address` or `read` are ignored. The fill always completes for the latched block. The current `address` is re-evaluated in IDLE afterwards; it may hit, or start a new miss.
- The cache is read-only: no write path, no dirty bits. Replacement is overwrite of the indexed line.

## Timing
- Reset asserted, at any time including mid-fill:
  - all valid bits = 0, state = IDLE;
  - `mem_read`=0, `mem_address`=0;
  - `busywait` follows `read` (all lookups miss).
  - Tag and data arrays need not be cleared.
- Hit latency: 0 cycles; `busywait` stays 0.
- Miss timeline:
  - cycle 0: `busywait`=1.
  - edge 1: enter MEM_REQ.
  - edge 2: enter MEM_WAIT.
  - edge E, first edge with `mem_busywait`=0 in MEM_WAIT: line written, enter IDLE.
  - cycle after E: hit, `busywait`=0.
- With the 16-cycle block memory, `busywait` stays high for 19 cycles total.
- A `mem_busywait` that stays high for any number of cycles extends MEM_WAIT without limit. There is no timeout.
- Back-to-back misses to different lines pass through IDLE for one cycle between fills.

## Structure
- Shared package holds:
  - FSM state enum (IDLE/MEM_REQ/MEM_WAIT);
  - `BLOCK_W`=128, `WORD_W`=32, `OFFSET_W`=4;
  - derived `TAG_W` and `INDEX_W`.
- Optional sub-module `icache_fill_fsm`: owns the state, the latched miss tag/index, `mem_read` and `mem_address`, and produces a one-cycle `fill_en`.
- The top level keeps the arrays, the hit compare, and the word mux.

## Test plan
- **Cold miss after reset.** Reset, then read 0x00000000 with the memory model's word0=0x3E800093.
  - Expect `mem_read` asserted with `mem_address`=0x0000000.
  - Expect `busywait` high for 19 cycles.
  - Expect `instruction`=0x3E800093 with `busywait`=0.
- **Hits in a filled line.** Following the cold miss, read 0x4, 0x8 and 0xC on consecutive cycles.
  - Expect `busywait`=0 every cycle, with no `mem_read`.
  - Expect words 1–3 of block 0.
- **Conflict.** Read 0x80 (index 0, tag 1).
  - Expect a miss with `mem_address`=0x0000008; line 0 is replaced.
  - A subsequent read of 0x0 misses again and refetches block 0.
- **Address change mid-fill.** During MEM_WAIT for 0x0, change `address` to 0x10 and drop `read` for 3 cycles.
  - Expect `mem_address` to stay 0x0000000 and the fill to complete.
  - Then 0x10 misses and fetches 0x0000001.
- **Reset mid-fill.** Pull `reset` low during MEM_WAIT.
  - Expect `mem_read`=0 immediately and the FSM in IDLE.
  - After release, a read of 0x0 misses (valid cleared).
- **Stretched memory.** Memory model holds `mem_busywait` high for 40 cycles.
  - Expect `mem_read` and `mem_address` stable throughout.
  - Expect `busywait` to fall exactly 1 cycle after the fill edge.
